// File: rtl/pinwheel_ram_arb.sv
// Two-requester round-robin arbiter in front of a single-port-per-direction RAM.
// Reads and full-mask writes take one cycle; partial-mask writes do a read-modify-write.
module pinwheel_ram_arb #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDR_BITS-1:0]     a_addr,
    input  logic [DATA_BITS-1:0]     a_wdata,
    input  logic [DATA_BITS/8-1:0]   a_mask,
    output logic                     a_ack,
    output logic                     a_rvalid,
    output logic [DATA_BITS-1:0]     a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [ADDR_BITS-1:0]     b_addr,
    input  logic [DATA_BITS-1:0]     b_wdata,
    input  logic [DATA_BITS/8-1:0]   b_mask,
    output logic                     b_ack,
    output logic                     b_rvalid,
    output logic [DATA_BITS-1:0]     b_rdata,
    output logic [ADDR_BITS-1:0]     ram_raddr,
    input  logic [DATA_BITS-1:0]     ram_rdata,
    output logic [ADDR_BITS-1:0]     ram_waddr,
    output logic [DATA_BITS-1:0]     ram_wdata,
    output logic                     ram_wren
);

    localparam int unsigned MASK_BITS = DATA_BITS / 8;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   ptr_q, ptr_d;          // 0 = A has priority, 1 = B
    logic                   a_rvalid_q, a_rvalid_d;
    logic                   b_rvalid_q, b_rvalid_d;
    logic [ADDR_BITS-1:0]   raddr_q, raddr_d;
    logic [ADDR_BITS-1:0]   rmw_addr_q, rmw_addr_d;
    logic [DATA_BITS-1:0]   rmw_wdata_q, rmw_wdata_d;
    logic [MASK_BITS-1:0]   rmw_mask_q, rmw_mask_d;

    logic                   sel_we;
    logic [ADDR_BITS-1:0]   sel_addr;
    logic [DATA_BITS-1:0]   sel_wdata;
    logic [MASK_BITS-1:0]   sel_mask;
    logic [DATA_BITS-1:0]   merged;

    // Byte merge of latched write data over the old word returned by the RAM
    always_comb begin
        merged = ram_rdata;
        for (int unsigned i = 0; i < MASK_BITS; i++) begin
            if (rmw_mask_q[i]) begin
                merged[i*8 +: 8] = rmw_wdata_q[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        raddr_d     = raddr_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        rmw_mask_d  = rmw_mask_q;
        a_ack       = 1'b0;
        b_ack       = 1'b0;
        ram_wren    = 1'b0;
        ram_raddr   = raddr_q;
        sel_we      = a_we;
        sel_addr    = a_addr;
        sel_wdata   = a_wdata;
        sel_mask    = a_mask;
        ram_waddr   = sel_addr;
        ram_wdata   = sel_wdata;

        if (rst_n) begin
            if (state_q == IDLE) begin
                a_ack = a_req && (!b_req || !ptr_q);
                b_ack = b_req && !a_ack;
                if (b_ack) begin
                    sel_we    = b_we;
                    sel_addr  = b_addr;
                    sel_wdata = b_wdata;
                    sel_mask  = b_mask;
                end
                ram_waddr = sel_addr;
                ram_wdata = sel_wdata;
                if (a_ack || b_ack) begin
                    ptr_d = a_ack;
                    if (!sel_we) begin
                        ram_raddr  = sel_addr;
                        a_rvalid_d = a_ack;
                        b_rvalid_d = b_ack;
                    end else if (&sel_mask) begin
                        ram_wren = 1'b1;
                    end else if (|sel_mask) begin
                        // Partial write: fetch the old word now, merge next cycle
                        ram_raddr   = sel_addr;
                        rmw_addr_d  = sel_addr;
                        rmw_wdata_d = sel_wdata;
                        rmw_mask_d  = sel_mask;
                        state_d     = RMW;
                    end
                end
            end else begin
                ram_raddr = rmw_addr_q;
                ram_waddr = rmw_addr_q;
                ram_wdata = merged;
                ram_wren  = 1'b1;
                state_d   = IDLE;
            end
        end
        raddr_d = ram_raddr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // Datapath registers carry no reset value
    always_ff @(posedge clk) begin
        raddr_q     <= raddr_d;
        rmw_addr_q  <= rmw_addr_d;
        rmw_wdata_q <= rmw_wdata_d;
        rmw_mask_q  <= rmw_mask_d;
    end

    // A reset arriving in the data-return cycle squashes that read's valid
    assign a_rvalid = a_rvalid_q & rst_n;
    assign b_rvalid = b_rvalid_q & rst_n;
    assign a_rdata  = ram_rdata;
    assign b_rdata  = ram_rdata;

endmodule

// File: tb/tb_pinwheel_ram_arb.sv
// Directed bench for pinwheel_ram_arb with a behavioural 1-cycle RAM and a read scoreboard.
module tb_pinwheel_ram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [9:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_mask, b_mask;
    logic        a_ack, b_ack, a_rvalid, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [9:0]  ram_raddr, ram_waddr;
    logic [31:0] ram_rdata, ram_wdata;
    logic        ram_wren;

    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] mem [1024];

    typedef struct {
        int          due;
        bit          is_b;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pinwheel_ram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .ram_wren(ram_wren)
    );

    // RAM model: registered read, write on the same edge
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_wren) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
        cyc++;
    endtask

    // Compare rvalid/rdata against whatever the scoreboard says is due this cycle
    task automatic chk_rv();
        logic exp_a, exp_b;
        exp_t e;
        exp_a = 1'b0;
        exp_b = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.is_b) begin
                exp_b = 1'b1;
                chk("b_rdata", b_rdata, e.data);
            end else begin
                exp_a = 1'b1;
                chk("a_rdata", a_rdata, e.data);
            end
        end
        chk("a_rvalid", 32'(a_rvalid), 32'(exp_a));
        chk("b_rvalid", 32'(b_rvalid), 32'(exp_b));
    endtask

    task automatic push(input bit is_b, input logic [31:0] data);
        exp_t e;
        e.due  = cyc + 1;
        e.is_b = is_b;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic set_a(input logic req, input logic we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [3:0] m);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_mask = m;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [9:0] addr,
                         input logic [31:0] wd, input logic [3:0] m);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_mask = m;
    endtask

    task automatic acks(input logic ea, input logic eb);
        chk("a_ack", 32'(a_ack), 32'(ea));
        chk("b_ack", 32'(b_ack), 32'(eb));
    endtask

    initial begin
        logic [9:0]  pl_addr [6];
        logic [31:0] pl_data [6];
        pl_addr = '{10'd5, 10'd9, 10'd3, 10'd20, 10'd21, 10'd40};
        pl_data = '{32'hDEADBEEF, 32'h11223344, 32'h0, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hCAFEF00D};

        rst_n = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        next();

        // Preload RAM while reset is held; requests must be ignored
        for (int i = 0; i < 6; i++) begin
            ld_en = 1'b1; ld_addr = pl_addr[i]; ld_data = pl_data[i];
            set_a(1'b1, 1'b1, 10'd7, '1, '1);
            set_b(1'b1, 1'b0, 10'd7, '0, '0);
            #1;
            acks(1'b0, 1'b0);
            chk("reset_wren", 32'(ram_wren), 32'd0);
            next();
        end
        ld_en = 1'b0;
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        #1; chk_rv();
        next();

        // Single read of RAM[5]
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 10'd5, '0, '0);
        #1; acks(1'b1, 1'b0);
        chk("raddr_rd5", 32'(ram_raddr), 32'd5);
        push(1'b0, 32'hDEADBEEF);
        chk_rv();
        next();
        set_a(1'b0, 1'b0, '0, '0, '0);
        #1; acks(1'b0, 1'b0); chk_rv();
        next();

        // Reset so both-requester arbitration starts from A
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 1'b0, 10'd20, '0, '0);
            set_b(1'b1, 1'b0, 10'd21, '0, '0);
            #1;
            acks(i % 2 == 0, i % 2 == 1);
            chk_rv();
            push(i % 2 == 1, (i % 2 == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
            next();
        end
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        #1; chk_rv();
        next();

        // Partial write to 9, B waits through the RMW cycle then reads merged word
        set_a(1'b1, 1'b1, 10'd9, 32'hAABBCCDD, 4'b0101);
        #1; acks(1'b1, 1'b0);
        chk("rmw_ack_wren", 32'(ram_wren), 32'd0);
        chk("rmw_ack_raddr", 32'(ram_raddr), 32'd9);
        chk_rv();
        next();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b1, 1'b0, 10'd9, '0, '0);
        #1; acks(1'b0, 1'b0);
        chk("rmw_wren", 32'(ram_wren), 32'd1);
        chk("rmw_waddr", 32'(ram_waddr), 32'd9);
        chk("rmw_wdata", ram_wdata, 32'h11BB33DD);
        chk("rmw_raddr", 32'(ram_raddr), 32'd9);
        chk_rv();
        next();
        #1; acks(1'b0, 1'b1);
        chk("post_rmw_wren", 32'(ram_wren), 32'd0);
        push(1'b1, 32'h11BB33DD);
        chk_rv();
        next();
        set_b(1'b0, 1'b0, '0, '0, '0);
        #1; chk_rv();
        next();

        // Full write to 3 then immediate read-back
        set_a(1'b1, 1'b1, 10'd3, 32'h12345678, 4'b1111);
        #1; acks(1'b1, 1'b0);
        chk("full_wren", 32'(ram_wren), 32'd1);
        chk("full_waddr", 32'(ram_waddr), 32'd3);
        chk("full_wdata", ram_wdata, 32'h12345678);
        chk_rv();
        next();
        set_a(1'b1, 1'b0, 10'd3, '0, '0);
        #1; acks(1'b1, 1'b0);
        chk("rd_wren", 32'(ram_wren), 32'd0);
        push(1'b0, 32'h12345678);
        chk_rv();
        next();

        // Zero-mask write is a no-op; confirm by reading the word back
        set_a(1'b1, 1'b1, 10'd5, 32'hFFFFFFFF, 4'b0000);
        #1; acks(1'b1, 1'b0);
        chk("zero_wren", 32'(ram_wren), 32'd0);
        chk_rv();
        next();
        set_a(1'b1, 1'b0, 10'd5, '0, '0);
        #1; acks(1'b1, 1'b0);
        push(1'b0, 32'hDEADBEEF);
        chk_rv();
        next();

        // Pointer holds through idle cycles (last grant was A, so B wins next)
        set_a(1'b0, 1'b0, '0, '0, '0);
        #1; chk_rv();
        next();
        #1; acks(1'b0, 1'b0); chk_rv();
        next();
        set_a(1'b1, 1'b0, 10'd20, '0, '0);
        set_b(1'b1, 1'b0, 10'd21, '0, '0);
        #1; acks(1'b0, 1'b1);
        push(1'b1, 32'hB1B1B1B1);
        chk_rv();
        next();
        #1; acks(1'b1, 1'b0);
        push(1'b0, 32'hA0A0A0A0);
        chk_rv();
        next();

        // B full write then A read of the same word on the next cycle
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b1, 1'b1, 10'd50, 32'h55AA55AA, 4'b1111);
        #1; acks(1'b0, 1'b1);
        chk_rv();
        next();
        set_b(1'b0, 1'b0, '0, '0, '0);
        set_a(1'b1, 1'b0, 10'd50, '0, '0);
        #1; acks(1'b1, 1'b0);
        push(1'b0, 32'h55AA55AA);
        chk_rv();
        next();
        set_a(1'b0, 1'b0, '0, '0, '0);
        #1; chk_rv();
        next();

        // Reset during RMW aborts the partial write
        set_a(1'b1, 1'b1, 10'd40, 32'h00000000, 4'b0011);
        #1; acks(1'b1, 1'b0);
        chk_rv();
        next();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b1, 1'b0, 10'd21, '0, '0);
        rst_n = 1'b0;
        #1; acks(1'b0, 1'b0);
        chk("rst_rmw_wren", 32'(ram_wren), 32'd0);
        next();
        rst_n = 1'b1;
        set_b(1'b0, 1'b0, '0, '0, '0);
        #1; acks(1'b0, 1'b0);
        chk("post_rst_wren", 32'(ram_wren), 32'd0);
        chk_rv();
        next();
        chk("mem40_kept", mem[40], 32'hCAFEF00D);
        set_a(1'b1, 1'b0, 10'd40, '0, '0);
        set_b(1'b1, 1'b0, 10'd21, '0, '0);
        #1; acks(1'b1, 1'b0);
        push(1'b0, 32'hCAFEF00D);
        chk_rv();
        next();
        set_a(1'b0, 1'b0, '0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0, '0);
        #1; acks(1'b0, 1'b0);
        chk_rv();
        next();

        // Reset in the cycle after a read ack suppresses its rvalid
        set_a(1'b1, 1'b0, 10'd5, '0, '0);
        #1; acks(1'b1, 1'b0);
        chk_rv();
        next();
        set_a(1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1; chk_rv();
        next();
        rst_n = 1'b1;
        #1; chk_rv();
        next();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pinwheel_ram_arb.md
PINWHEEL_RAM_ARB -- requirements
Module: pinwheel_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word address width of the shared RAM (1024 words).
REQ-002 SHALL have parameter DATA_BITS, default 32, word width; byte mask width is DATA_BITS/8.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports a_req / b_req, input, 1, requester A/B has a command pending.
REQ-006 SHALL have ports a_we / b_we, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have ports a_addr / b_addr, input, ADDR_BITS, word address.
REQ-008 SHALL have ports a_wdata / b_wdata, input, DATA_BITS, write data.
REQ-009 SHALL have ports a_mask / b_mask, input, DATA_BITS/8, byte write enables; ignored for reads.
REQ-010 SHALL have ports a_ack / b_ack, output, 1, command accepted this cycle (combinational).
REQ-011 SHALL have ports a_rvalid / b_rvalid, output, 1, read data valid (registered).
REQ-012 SHALL have ports a_rdata / b_rdata, output, DATA_BITS, read data; qualified by rvalid.
REQ-013 SHALL have ports ram_raddr (output, ADDR_BITS), ram_rdata (input, DATA_BITS), ram_waddr (output, ADDR_BITS), ram_wdata (output, DATA_BITS), ram_wren (output, 1); RAM read latency is exactly one clock.

Function
REQ-014 SHALL implement FSM states IDLE and RMW; commands are accepted only in IDLE.
REQ-015 SHALL hold a requester remains asserted with stable command fields until ack; the arbiter drops nothing once acked.
REQ-016 SHALL, in IDLE with exactly one req, ack that requester.
REQ-017 SHALL, in IDLE with both req, ack the requester indicated by a 1-bit round-robin pointer; pointer then points to the other requester.
REQ-018 SHALL update the pointer only on a grant; with no grant the pointer holds.
REQ-019 SHALL never assert a_ack and b_ack in the same cycle.
REQ-020 SHALL, for an acked read, drive ram_raddr=addr in the ack cycle and assert that requester's rvalid with rdata=ram_rdata exactly one cycle later.
REQ-021 SHALL, for an acked write with mask all-ones, drive ram_wren=1, ram_waddr=addr, ram_wdata=wdata in the ack cycle; no rvalid.
REQ-022 SHALL, for an acked write with mask all-zero, complete in the ack cycle with ram_wren=0 and no other effect.
REQ-023 SHALL, for an acked write with a partial mask: ack cycle drives ram_raddr=addr, latches addr/wdata/mask, moves to RMW; RMW cycle drives ram_wren=1, ram_waddr=latched addr, ram_wdata byte i = mask[i] ? wdata byte i : ram_rdata byte i; returns to IDLE next cycle.
REQ-024 SHALL deassert both acks during RMW; pending reqs wait; RMW cycle does not move the pointer.
REQ-025 SHALL keep ram_wren=0 in every cycle not named in REQ-021/REQ-023.
REQ-026 SHALL guarantee a read acked the cycle after a write to the same address returns the new data (write commits before the later read is issued).
REQ-027 SHALL have maximum throughput of one read or full write per cycle; partial write occupies two cycles.
REQ-028 SHALL drive ram_raddr with the latched RMW address during RMW, and hold the last value otherwise when idle.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge: state=IDLE, pointer=A, a_rvalid=b_rvalid=0, a_ack=b_ack=0, ram_wren=0.
REQ-030 SHALL, on reset asserted during RMW, abort the pending partial write (no ram_wren in that or the following cycle).
REQ-031 SHALL, on reset asserted the cycle after a read ack, suppress that read's rvalid.
REQ-032 SHALL require rdata outputs need no reset value.

Verification
REQ-033 SHALL cover: reset then a_req read addr 5 (RAM[5]=0xDEADBEEF) -> a_ack cycle 0, a_rvalid=1 with a_rdata=0xDEADBEEF cycle 1, b_rvalid=0.
REQ-034 SHALL cover: a_req and b_req reads held 4 cycles after reset -> acks A,B,A,B alternate, one per cycle, rvalids follow one cycle later.
REQ-035 SHALL cover: RAM[9]=0x11223344, A writes addr 9 wdata 0xAABBCCDD mask 0b0101 -> ack, one RMW cycle, ram_wdata=0x11BB33DD with ram_wren=1; then B read of 9 returns 0x11BB33DD.
REQ-036 SHALL cover: B req asserted during A's RMW cycle -> b_ack=0 in RMW, b_ack=1 next cycle.
REQ-037 SHALL cover: A write addr 3 full mask 0x12345678 then A read addr 3 next cycle -> rdata=0x12345678.
REQ-038 SHALL cover: rst_n=0 in RMW cycle -> ram_wren=0, RAM unchanged, pointer=A, all acks/rvalids 0 afterwards.
